// File: rtl/piano_ps2_pkg.sv
// Shared scan-code constants, arrow bit positions and frame FSM encoding
// for the PS/2 arrow-key receiver.
package piano_ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int ARROW_LEFT  = 0;
    localparam int ARROW_DOWN  = 1;
    localparam int ARROW_UP    = 2;
    localparam int ARROW_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // One-hot arrow mask for an extended scan code; zero for anything else.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_LEFT:  m[ARROW_LEFT]  = 1'b1;
            SC_DOWN:  m[ARROW_DOWN]  = 1'b1;
            SC_UP:    m[ARROW_UP]    = 1'b1;
            SC_RIGHT: m[ARROW_RIGHT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host byte receiver: synchronizers, clock glitch filter,
// 11-bit framing FSM with odd-parity/stop checks and an inactivity timeout.
module ps2_frame_rx
    import piano_ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_filt;
    logic [FILT_W-1:0] r_filt_cnt;
    logic              w_filt_flip;
    logic              w_fall;

    frame_state_t      r_state, w_state_next;
    logic [2:0]        r_bit_cnt, w_bit_cnt_next;
    logic [7:0]        r_shift, w_shift_next;
    logic              r_par_err, w_par_err_next;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_next;
    logic [7:0]        r_code, w_code_next;
    logic              r_valid, w_valid_next;
    logic              r_err, w_err_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filter counts consecutive samples that disagree with the current
    // filtered level; the FILTER_LEN-th such sample flips it.
    assign w_filt_flip = (r_clk_s2 != r_filt) && (r_filt_cnt == FILT_W'(FILTER_LEN - 1));
    assign w_fall      = w_filt_flip && r_filt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt     <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_to_cnt  <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_par_err <= w_par_err_next;
            r_to_cnt  <= w_to_cnt_next;
            r_code    <= w_code_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_par_err_next = r_par_err;
        w_code_next    = r_code;
        w_valid_next   = 1'b0;
        w_err_next     = 1'b0;
        w_to_cnt_next  = (r_state == IDLE || w_fall) ? '0 : r_to_cnt + 1'b1;

        if (r_state != IDLE && !w_fall && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_next   = DATA;
                        w_bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    w_shift_next   = {r_dat_s2, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_par_err_next = ~(^r_shift ^ r_dat_s2);
                    w_state_next   = STOP;
                end
                STOP: begin
                    if (r_dat_s2 && !r_par_err) begin
                        w_valid_next = 1'b1;
                        w_code_next  = r_shift;
                    end else begin
                        w_err_next = 1'b1;
                    end
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign scan_code   = r_code;
    assign scan_valid  = r_valid;
    assign frame_error = r_err;

endmodule

// File: rtl/ps2_arrow_receiver.sv
// PS/2 scan-code set 2 arrow-key decoder: held levels plus one-cycle make
// pulses for left/down/up/right, on top of the raw byte receiver.
module ps2_arrow_receiver
    import piano_ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error,
    output logic [3:0] arrow_held,
    output logic [3:0] arrow_press
);

    logic [7:0] w_code;
    logic       w_valid;
    logic       w_err;
    logic [3:0] w_mask;
    logic       r_ext, r_brk;
    logic [3:0] r_held, r_press;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .scan_code   (w_code),
        .scan_valid  (w_valid),
        .frame_error (w_err)
    );

    assign w_mask = arrow_mask(w_code);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_held  <= 4'b0000;
            r_press <= 4'b0000;
        end else begin
            r_press <= 4'b0000;
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_valid) begin
                if (w_code == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_code == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    // Only a fresh make pulses; typematic repeats of a held key stay silent.
                    if (r_ext && w_mask != 4'b0000) begin
                        if (r_brk) begin
                            r_held <= r_held & ~w_mask;
                        end else if ((r_held & w_mask) == 4'b0000) begin
                            r_held  <= r_held | w_mask;
                            r_press <= w_mask;
                        end
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign scan_code   = w_code;
    assign scan_valid  = w_valid;
    assign frame_error = w_err;
    assign arrow_held  = r_held;
    assign arrow_press = r_press;

endmodule

// File: tb/tb_ps2_arrow_receiver.sv
// Randomized and directed bench for ps2_arrow_receiver, checked against a
// byte-stream model of the make/break decoding rules.
module tb_ps2_arrow_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;
    logic [3:0] arrow_held;
    logic [3:0] arrow_press;

    ps2_arrow_receiver #(
        .FILTER_LEN     (2),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_error (frame_error),
        .arrow_held  (arrow_held),
        .arrow_press (arrow_press)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_sv    = 0;
    int n_err   = 0;
    int n_press = 0;
    int n_late  = 0;
    int sv_cyc  = -10;
    int err_cyc = 0;
    int last_fall = 0;
    int tx_num  = 0;
    logic [3:0] last_press = 4'b0000;

    // Model state: prefix bytes (E0/F0) seen since the last completed key code.
    logic [7:0] pending[$];
    logic [3:0] exp_held = 4'b0000;
    logic [7:0] exp_code = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (scan_valid) begin
            n_sv   = n_sv + 1;
            sv_cyc = cyc;
        end
        if (frame_error) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
        if (arrow_press != 4'b0000) begin
            n_press    = n_press + 1;
            last_press = arrow_press;
            if (cyc != sv_cyc + 1) n_late = n_late + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] key_bit(input logic [7:0] b);
        if (b == 8'h6B) return 4'b0001;
        if (b == 8'h72) return 4'b0010;
        if (b == 8'h75) return 4'b0100;
        if (b == 8'h74) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic [3:0] press);
        bit has_ext = 0;
        bit has_brk = 0;
        logic [3:0] k;
        press = 4'b0000;
        if (b == 8'hE0 || b == 8'hF0) begin
            pending.push_back(b);
        end else begin
            foreach (pending[i]) begin
                if (pending[i] == 8'hE0) has_ext = 1;
                if (pending[i] == 8'hF0) has_brk = 1;
            end
            k = key_bit(b);
            if (has_ext && k != 4'b0000) begin
                if (has_brk) exp_held = exp_held & ~k;
                else if ((exp_held & k) == 4'b0000) begin
                    exp_held = exp_held | k;
                    press    = k;
                end
            end
            pending.delete();
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        logic par;
        par = ~^b;
        fr  = {1'b1, bad ? ~par : par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            tick(20);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            tick(20);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad);
        int sv0, err0, pr0, late0;
        logic [3:0] ep;
        sv0 = n_sv; err0 = n_err; pr0 = n_press; late0 = n_late;
        send_bits(b, bad, 11);
        tick(20);
        if (bad) begin
            pending.delete();
            ep = 4'b0000;
        end else begin
            exp_code = b;
            model_byte(b, ep);
        end
        check("scan_valid_cnt", n_sv - sv0, bad ? 0 : 1);
        check("frame_error_cnt", n_err - err0, bad ? 1 : 0);
        check("scan_code", scan_code, exp_code);
        check("press_cnt", n_press - pr0, (ep != 4'b0000) ? 1 : 0);
        if (ep != 4'b0000) check("press_mask", last_press, ep);
        check("press_latency", n_late - late0, 0);
        check("held", arrow_held, exp_held);
        tx_num++;
        $display("[TB] tx %0d byte %02h%s press=%b held=%b", tx_num, b,
                 bad ? " badpar" : "", ep, exp_held);
    endtask

    initial begin
        int err0;
        int r;
        logic [7:0] b;
        logic [7:0] arrows [4];
        arrows[0] = 8'h6B; arrows[1] = 8'h72; arrows[2] = 8'h75; arrows[3] = 8'h74;

        tick(5);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_outputs", {scan_valid, frame_error, arrow_held, arrow_press}, 10'h000);
        reset = 1'b0;
        tick(10);

        // Up make, typematic repeat, break
        do_frame(8'hE0, 0); do_frame(8'h75, 0);
        do_frame(8'hE0, 0); do_frame(8'h75, 0);
        do_frame(8'hE0, 0); do_frame(8'hF0, 0); do_frame(8'h75, 0);
        // Two keys held, release one
        do_frame(8'hE0, 0); do_frame(8'h6B, 0);
        do_frame(8'hE0, 0); do_frame(8'h74, 0);
        do_frame(8'hE0, 0); do_frame(8'hF0, 0); do_frame(8'h6B, 0);
        // Parity error clears the extended prefix
        do_frame(8'hE0, 0); do_frame(8'h75, 1); do_frame(8'h75, 0);

        // Timeout after 5 bits of a frame
        err0 = n_err;
        send_bits(8'h72, 0, 5);
        tick(300);
        pending.delete();
        check("timeout_err_cnt", n_err - err0, 1);
        check("timeout_delay_ok", (err_cyc - last_fall >= 198 && err_cyc - last_fall <= 212) ? 1 : 0, 1);
        $display("[TB] tx timeout err_delay=%0d", err_cyc - last_fall);
        do_frame(8'hE0, 0); do_frame(8'h72, 0);

        // Keypad code without prefix
        do_frame(8'h75, 0);

        // Reset during bit 4 of a frame
        err0 = n_err;
        send_bits(8'h5A, 0, 4);
        ps2_dat = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(3);
        check("midrst_scan_code", scan_code, 8'h00);
        check("midrst_held", arrow_held, 4'b0000);
        reset   = 1'b0;
        ps2_clk = 1'b1;
        tick(300);
        check("midrst_no_err", n_err - err0, 0);
        pending.delete();
        exp_held = 4'b0000;
        exp_code = 8'h00;
        $display("[TB] tx reset mid-frame");
        do_frame(8'hE0, 0); do_frame(8'h74, 0);

        // Randomized byte stream
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) do_frame(8'hE0, 0);
            else if (r == 3) do_frame(8'hF0, 0);
            else if (r <= 7) do_frame(arrows[$urandom_range(0, 3)], 0);
            else begin
                b = 8'($urandom_range(0, 255));
                do_frame(b, r == 9);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
